// File: rtl/fp_operand_issuer_pkg.sv
// fpu_pkg: shared types and constants for the FP operand issuer and its classifier.
package fpu_pkg;
    localparam int EXP_W = 8;
    localparam int FRAC_W = 23;
    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
    localparam logic [31:0] QNAN = 32'h7FFF_FFFF;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} issuer_state_t;
    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
        logic              inf;
        logic              nan;
    } fp_unpacked_t;
endpackage

// File: rtl/fp_operand_issuer_if.sv
// fp_operand_issuer_if: operand handshake plus unpacked issue bus toward the FP multiplier.
// Carries ftz_o only when FP_ISSUER_FTZ_EN is defined.
interface fp_operand_issuer_if;
    logic        operand_valid_i;
    logic        operand_ready_o;
    logic [31:0] x_i;
    logic [31:0] y_i;
    logic        result_valid_i;
    logic        data_valid_o;
    logic        x_sign_o;
    logic        y_sign_o;
    logic [7:0]  x_exp_o;
    logic [7:0]  y_exp_o;
    logic [22:0] x_frac_o;
    logic [22:0] y_frac_o;
    logic        x_infinity_o;
    logic        y_infinity_o;
    logic        x_nan_o;
    logic        y_nan_o;
    logic        busy_o;
    logic        timeout_o;
`ifdef FP_ISSUER_FTZ_EN
    logic        ftz_o;
`endif
    modport slave (
        input  operand_valid_i, x_i, y_i, result_valid_i,
        output operand_ready_o, data_valid_o, x_sign_o, y_sign_o, x_exp_o, y_exp_o,
               x_frac_o, y_frac_o, x_infinity_o, y_infinity_o, x_nan_o, y_nan_o,
               busy_o, timeout_o
`ifdef FP_ISSUER_FTZ_EN
        , output ftz_o
`endif
    );
    modport master (
        output operand_valid_i, x_i, y_i, result_valid_i,
        input  operand_ready_o, data_valid_o, x_sign_o, y_sign_o, x_exp_o, y_exp_o,
               x_frac_o, y_frac_o, x_infinity_o, y_infinity_o, x_nan_o, y_nan_o,
               busy_o, timeout_o
`ifdef FP_ISSUER_FTZ_EN
        , input ftz_o
`endif
    );
endinterface

// File: rtl/fp_operand_issuer_classify.sv
// fp_classify: slices a packed single-precision word into fields and inf/nan flags.
// With FP_ISSUER_FTZ_EN defined, subnormal fractions are flushed and reported.
module fp_classify
    import fpu_pkg::*;
(
    input  logic [31:0]  word,
    output fp_unpacked_t fp
`ifdef FP_ISSUER_FTZ_EN
    , output logic       flushed
`endif
);
    logic [EXP_W-1:0]  e;
    logic [FRAC_W-1:0] f;
    assign e = word[30:23];
    assign f = word[22:0];
    assign fp.sign = word[31];
    assign fp.exp = e;
    assign fp.inf = e == EXP_MAX && f == '0;
    assign fp.nan = e == EXP_MAX && f != '0;
`ifdef FP_ISSUER_FTZ_EN
    assign flushed = e == '0 && f != '0;
    assign fp.frac = flushed ? '0 : f;
`else
    assign fp.frac = f;
`endif
endmodule

// File: rtl/fp_operand_issuer.sv
// fp_operand_issuer: buffers one operand pair, classifies it and issues a one-cycle pulse to the multiplier.
// Optional subnormal flush-to-zero with ftz_o when FP_ISSUER_FTZ_EN is defined.
module fp_operand_issuer
    import fpu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W = 8
) (
    input logic                clk_i,
    input logic                rst_i,
    fp_operand_issuer_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    issuer_state_t    state;
    logic             buf_full;
    logic             accept;
    logic [31:0]      x_q;
    logic [31:0]      y_q;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    fp_unpacked_t     xu;
    fp_unpacked_t     yu;
    assign accept = bus.operand_valid_i && !buf_full;
    assign bus.operand_ready_o = !buf_full;
    assign cnt_inc = &cnt ? cnt : cnt + 1'b1;
`ifdef FP_ISSUER_FTZ_EN
    logic x_ftz;
    logic y_ftz;
    fp_classify u_x (.word(x_q), .fp(xu), .flushed(x_ftz));
    fp_classify u_y (.word(y_q), .fp(yu), .flushed(y_ftz));
`else
    fp_classify u_x (.word(x_q), .fp(xu));
    fp_classify u_y (.word(y_q), .fp(yu));
`endif
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
            buf_full <= 1'b0;
            x_q <= '0;
            y_q <= '0;
            cnt <= '0;
            bus.data_valid_o <= 1'b0;
            bus.timeout_o <= 1'b0;
            bus.busy_o <= 1'b0;
            bus.x_sign_o <= 1'b0;
            bus.y_sign_o <= 1'b0;
            bus.x_exp_o <= '0;
            bus.y_exp_o <= '0;
            bus.x_frac_o <= '0;
            bus.y_frac_o <= '0;
            bus.x_infinity_o <= 1'b0;
            bus.y_infinity_o <= 1'b0;
            bus.x_nan_o <= 1'b0;
            bus.y_nan_o <= 1'b0;
`ifdef FP_ISSUER_FTZ_EN
            bus.ftz_o <= 1'b0;
`endif
        end else begin
            if (accept) begin
                x_q <= bus.x_i;
                y_q <= bus.y_i;
            end
            // a fresh accept wins over the IDLE drain so a prefetched pair is never lost
            buf_full <= accept || (buf_full && state != IDLE);
            bus.data_valid_o <= 1'b0;
            bus.timeout_o <= 1'b0;
`ifdef FP_ISSUER_FTZ_EN
            bus.ftz_o <= 1'b0;
`endif
            case (state)
                IDLE: if (buf_full) begin
                    state <= ISSUE;
                    bus.busy_o <= 1'b1;
                    bus.data_valid_o <= 1'b1;
                    bus.x_sign_o <= xu.sign;
                    bus.y_sign_o <= yu.sign;
                    bus.x_exp_o <= xu.exp;
                    bus.y_exp_o <= yu.exp;
                    bus.x_frac_o <= xu.frac;
                    bus.y_frac_o <= yu.frac;
                    bus.x_infinity_o <= xu.inf;
                    bus.y_infinity_o <= yu.inf;
                    bus.x_nan_o <= xu.nan;
                    bus.y_nan_o <= yu.nan;
`ifdef FP_ISSUER_FTZ_EN
                    bus.ftz_o <= x_ftz || y_ftz;
`endif
                end
                ISSUE: begin
                    cnt <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    cnt <= cnt_inc;
                    // completion takes priority over a coinciding watchdog expiry
                    if (bus.result_valid_i || cnt_inc == CNT_LAST) begin
                        state <= IDLE;
                        bus.busy_o <= 1'b0;
                        bus.timeout_o <= !bus.result_valid_i;
                    end
                end
                default: begin
                    state <= IDLE;
                    bus.busy_o <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fp_operand_issuer.sv
// tb_fp_operand_issuer: table-driven vectors with a scoreboard queue, plus prefetch, watchdog and reset sequences.
module tb_fp_operand_issuer;
    import fpu_pkg::*;
    localparam int T = 16;
    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic        xi;
        logic        xn;
        logic        yi;
        logic        yn;
        logic        ftz;
    } vec_t;
    typedef struct packed {
        logic        xs;
        logic [7:0]  xe;
        logic [22:0] xf;
        logic        ys;
        logic [7:0]  ye;
        logic [22:0] yf;
        logic [3:0]  flags;
        logic        ftz;
    } exp_t;
    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    int vectors = 0;
    int miscompares = 0;
    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[6];
    fp_operand_issuer_if bus();
    fp_operand_issuer #(.TIMEOUT_CYCLES(T), .CNT_W(8)) dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));
    always #5 clk_i = ~clk_i;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask
    function automatic exp_t model(input vec_t v);
        exp_t e;
        e.xs = v.x[31];
        e.xe = v.x[30:23];
        e.xf = v.x[22:0];
        e.ys = v.y[31];
        e.ye = v.y[30:23];
        e.yf = v.y[22:0];
        e.flags = {v.xi, v.xn, v.yi, v.yn};
        e.ftz = 1'b0;
`ifdef FP_ISSUER_FTZ_EN
        if (e.xe == 8'h00) e.xf = '0;
        if (e.ye == 8'h00) e.yf = '0;
        e.ftz = v.ftz;
`endif
        return e;
    endfunction
    always @(negedge clk_i) begin
        if (rst_i && bus.data_valid_o) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_issue: got data_valid_o=1 expected no pending pair at %0t", $time);
            end else begin
                mon_e = sb.pop_front();
                check("x_fields", {bus.x_sign_o, bus.x_exp_o, bus.x_frac_o}, {mon_e.xs, mon_e.xe, mon_e.xf});
                check("y_fields", {bus.y_sign_o, bus.y_exp_o, bus.y_frac_o}, {mon_e.ys, mon_e.ye, mon_e.yf});
                check("flags", {28'd0, bus.x_infinity_o, bus.x_nan_o, bus.y_infinity_o, bus.y_nan_o}, {28'd0, mon_e.flags});
`ifdef FP_ISSUER_FTZ_EN
                check("ftz", {31'd0, bus.ftz_o}, {31'd0, mon_e.ftz});
`endif
            end
        end
    end
    // call right after a negedge; returns right after the negedge following acceptance
    task automatic send(input vec_t v);
        logic done = 1'b0;
        bus.x_i = v.x;
        bus.y_i = v.y;
        bus.operand_valid_i = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            done = bus.operand_ready_o;
            @(posedge clk_i);
            if (done) sb.push_back(model(v));
            @(negedge clk_i);
        end
        bus.operand_valid_i = 1'b0;
        check("send_accepted", {31'd0, done}, 32'd1);
    endtask
    task automatic wait_issue(output int n);
        n = 0;
        for (int i = 1; i <= 60 && n == 0; i++) begin
            @(negedge clk_i);
            if (bus.data_valid_o) n = i;
        end
    endtask
    task automatic pulse_result();
        bus.result_valid_i = 1'b1;
        @(negedge clk_i);
        bus.result_valid_i = 1'b0;
    endtask
    initial begin
        int n;
        logic seen;
        vecs[0] = '{32'h3F80_0000, 32'h4000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{32'h7F80_0000, 32'hFFC0_0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{32'h0000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{32'h7F80_0001, 32'hFF80_0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{32'h0000_0001, 32'h3F80_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{32'h807F_FFFF, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        bus.operand_valid_i = 1'b0;
        bus.result_valid_i = 1'b0;
        bus.x_i = '0;
        bus.y_i = '0;
        repeat (3) @(negedge clk_i);
        check("rst_ready", {31'd0, bus.operand_ready_o}, 32'd1);
        check("rst_outs", {bus.data_valid_o, bus.busy_o, bus.timeout_o, bus.x_exp_o, bus.y_frac_o}, 32'd0);
        rst_i = 1'b1;
        @(negedge clk_i);
        for (int i = 0; i < 6; i++) begin
            send(vecs[i]);
            check("pre_issue_dv", {31'd0, bus.data_valid_o}, 32'd0);
            wait_issue(n);
            check("issue_latency", n, 32'd1);
            @(negedge clk_i);
            check("pulse_width", {31'd0, bus.data_valid_o}, 32'd0);
            check("busy_wait", {31'd0, bus.busy_o}, 32'd1);
            pulse_result();
            check("busy_done", {31'd0, bus.busy_o}, 32'd0);
            check("fields_hold", {24'd0, bus.x_exp_o}, {24'd0, vecs[i].x[30:23]});
        end
        // spurious completion while idle
        pulse_result();
        repeat (2) @(negedge clk_i);
        check("spurious_busy", {31'd0, bus.busy_o}, 32'd0);
        check("spurious_sb", sb.size(), 32'd0);
        // prefetch and backpressure
        send(vecs[0]);
        send(vecs[1]);
        check("prefetch_ready", {31'd0, bus.operand_ready_o}, 32'd0);
        check("prefetch_busy", {31'd0, bus.busy_o}, 32'd1);
        fork
            send(vecs[3]);
            begin
                repeat (3) @(negedge clk_i);
                check("stall_ready", {31'd0, bus.operand_ready_o}, 32'd0);
                check("stall_sb", sb.size(), 32'd1);
                pulse_result();
            end
        join
        check("p3_pending", sb.size(), 32'd1);
        pulse_result();
        wait_issue(n);
        check("p3_issued", {31'd0, n != 0}, 32'd1);
        @(negedge clk_i);
        pulse_result();
        check("prefetch_drained", sb.size(), 32'd0);
        // watchdog expiry
        send(vecs[2]);
        wait_issue(n);
        n = 0;
        for (int j = 1; j <= 60 && n == 0; j++) begin
            @(negedge clk_i);
            if (bus.timeout_o) n = j;
        end
        check("timeout_delay", n, T);
        check("timeout_idle", {31'd0, bus.busy_o}, 32'd0);
        @(negedge clk_i);
        check("timeout_pulse", {31'd0, bus.timeout_o}, 32'd0);
        // completion on the final count cycle suppresses the watchdog
        send(vecs[0]);
        wait_issue(n);
        repeat (T - 1) @(negedge clk_i);
        pulse_result();
        check("late_result_busy", {31'd0, bus.busy_o}, 32'd0);
        seen = bus.timeout_o;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk_i);
            seen |= bus.timeout_o;
        end
        check("late_result_no_timeout", {31'd0, seen}, 32'd0);
        // asynchronous reset mid-WAIT with a pair buffered
        send(vecs[1]);
        send(vecs[0]);
        check("pre_rst_busy", {31'd0, bus.busy_o}, 32'd1);
        #2 rst_i = 1'b0;
        #1;
        check("async_rst_outs", {bus.data_valid_o, bus.busy_o, bus.timeout_o, bus.x_infinity_o, bus.y_nan_o, bus.x_exp_o, bus.y_exp_o}, 32'd0);
        check("async_rst_frac", {9'd0, bus.y_frac_o}, 32'd0);
        check("async_rst_ready", {31'd0, bus.operand_ready_o}, 32'd1);
        sb.delete();
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        seen = 1'b0;
        for (int j = 0; j < 30; j++) begin
            @(negedge clk_i);
            seen |= bus.data_valid_o;
        end
        check("no_issue_after_rst", {31'd0, seen}, 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fp_operand_issuer.md
Name: fp_operand_issuer

Overview:
- Upstream neighbour of the FP multiplier.
- Accepts packed IEEE-754 single-precision operand pairs over a valid/ready handshake and buffers one pair.
- Unpacks and classifies each operand, then issues it to the multiplier as a one-cycle data-valid pulse.
- Blocks further issue until the multiplier reports completion, or until a watchdog expires.

Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles in WAIT before the watchdog fires (legal range 2..255).
- CNT_W, 8: width of the watchdog counter.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset (asserted at 0).
- operand_valid_i  in  1  upstream pair valid.
- operand_ready_o  out  1  buffer can accept a pair.
- x_i  in  32  packed operand X.
- y_i  in  32  packed operand Y.
- result_valid_i  in  1  multiplier completion pulse (its data_valid_o).
- data_valid_o  out  1  issue pulse to the multiplier.
- x_sign_o, y_sign_o  out  1  sign fields.
- x_exp_o, y_exp_o  out  8  biased exponents.
- x_frac_o, y_frac_o  out  23  fraction fields, no hidden bit.
- x_infinity_o, y_infinity_o  out  1  exp==8'hFF and frac==0.
- x_nan_o, y_nan_o  out  1  exp==8'hFF and frac!=0.
- busy_o  out  1  state is not IDLE.
- timeout_o  out  1  one-cycle watchdog pulse.

Behaviour:
- Reset (rst_i=0, asynchronous):
  - State goes to IDLE and the buffer empties.
  - Every output register clears to 0, including data_valid_o, timeout_o, busy_o, and all field and flag outputs.
  - operand_ready_o = 1 while rst_i=0, because it is combinational !buf_full. Transfers presented during reset are discarded.
- Accept: a transfer occurs on a rising edge when operand_valid_i and operand_ready_o are both 1. x_i and y_i are captured into the buffer and buf_full is set.
- operand_ready_o = !buf_full, with no combinational path from operand_valid_i.
- States:
  - IDLE: if buf_full, unpack and classify the buffer into the output registers, clear buf_full, and go to ISSUE. Otherwise stay.
  - ISSUE: data_valid_o=1 for exactly this cycle. Clear the counter and go to WAIT.
  - WAIT: the counter increments every cycle.
    - If result_valid_i=1, go to IDLE.
    - Otherwise, if the counter reaches TIMEOUT_CYCLES-1, pulse timeout_o for one cycle and go to IDLE.
    - If result_valid_i and the timeout coincide, the result wins and there is no timeout pulse.
- Latency: a pair accepted on edge N presents data_valid_o=1 in cycle N+2 when the state is IDLE. Back-to-back issues are separated by the multiplier latency plus 2 cycles.
- Field and flag outputs hold their values from the IDLE load until the next IDLE load; they do not return to 0 after issue.
- Simultaneous events:
  - A buffer drain in IDLE and a new accept on the same edge leave buf_full=1 holding the new pair.
  - A new pair may be accepted during ISSUE or WAIT, which prefetches it.
- Spurious input: result_valid_i outside WAIT is ignored and does not change state.
- Reset mid-operation: any buffered or in-flight pair is dropped and no data_valid_o pulse follows.
- Width and rules:
  - Fields are a pure bit slice: [31] is sign, [30:23] is exp, [22:0] is frac.
  - Zero (exp==0, frac==0) raises no flag; the multiplier detects zero itself.
  - The counter saturates and never wraps.

Optional Feature:
- Macro: FP_ISSUER_FTZ_EN.
- When defined, a subnormal operand (exp==0, frac!=0) has its frac output forced to 0, and the sign is kept. An extra output `ftz_o` (1 bit) pulses alongside data_valid_o when either operand was flushed.
- When undefined, subnormals pass through unchanged and the ftz_o port does not exist.

Decomposition:
- Package fpu_pkg holds:
  - the issuer state enum (IDLE, ISSUE, WAIT);
  - EXP_W=8, FRAC_W=23, EXP_MAX=8'hFF;
  - QNAN=32'h7FFF_FFFF;
  - a packed struct fp_unpacked_t {sign, exp, frac, inf, nan}.
- One combinational sub-module, fp_classify, instantiated twice: 32-bit word in, fp_unpacked_t out, with FTZ handling under the macro.

Test Plan:
- Reset and handshake: release reset, send x=32'h3F80_0000, y=32'h4000_0000 with valid held one cycle.
  - data_valid_o pulses 2 cycles later with x_exp_o=8'h7F, y_exp_o=8'h80, both frac=0, no flags.
  - busy_o is 1 until a result_valid_i pulse.
- Classification: x=32'h7F80_0000, y=32'hFFC0_0000.
  - x_infinity_o=1, y_nan_o=1, y_sign_o=1, y_frac_o=23'h40_0000.
- Prefetch and backpressure: send three pairs back-to-back with result_valid_i withheld.
  - Pair 1 issues and pair 2 is buffered.
  - operand_ready_o=0 and pair 3 stalls until pulsing result_valid_i lets pair 2 issue.
- Watchdog: issue, never assert result_valid_i.
  - timeout_o pulses exactly TIMEOUT_CYCLES cycles after ISSUE, then the state is IDLE.
  - result_valid_i on the final count cycle produces no timeout_o.
- Reset mid-WAIT with a pair buffered: drive rst_i low asynchronously between edges.
  - All outputs go to 0 immediately and no data_valid_o appears after release.
- FTZ (macro defined): x=32'h0000_0001.
  - x_frac_o=0 and ftz_o=1 with the issue pulse.
  - With the macro undefined, x_frac_o=23'h00_0001.
